ikaopll_dac_mixacc: RTL and testbench
=====================================

IKAOPLL_DAC_MIXACC -- requirements
Module: IKAOPLL_dac_mixacc

Interface
REQ-001 Parameter SMP_W, default 9: sign-magnitude sample width, bit SMP_W-1 = sign, lower bits = magnitude.
REQ-002 Parameter VOL_W, default 4: unsigned volume width per class.
REQ-003 Parameter ACC_W, default 16: signed accumulator and output width.
REQ-004 Parameter STRB_LEN, default 9: output strobe length in enabled cycles, range 1..31.
REQ-005 i_EMUCLK  input  1  emulator master clock; the only clock.
REQ-006 i_RST  input  1  asynchronous active-high reset.
REQ-007 i_phi1_NCEN_n  input  1  active-low clock enable; all state advances only on i_EMUCLK rising edges with this low.
REQ-008 i_FRAME_START  input  1  first slot of a sample frame.
REQ-009 i_SMP_VALID  input  1  i_SMP carries an operator output this slot.
REQ-010 i_SMP_CLASS  input  1  0 = melody (MO), 1 = rhythm (RO).
REQ-011 i_SMP  input  SMP_W  sign-magnitude sample.
REQ-012 i_MOVOL / i_ROVOL  input  VOL_W each  per-class gain.
REQ-013 i_MUTE_MO / i_MUTE_RO  input  1 each  drop that class's contributions.
REQ-014 o_ACC_MO / o_ACC_RO / o_ACC_MIX  output  ACC_W each, signed  per-class and mixed frame sums.
REQ-015 o_ACC_STRB  output  1  new-frame-result strobe.
REQ-016 o_SAT  output  1  a saturation occurred in the frame just published.
REQ-017 o_FRAME_CNT  output  8  count of frames published, wrapping.

Function
REQ-018 Conversion: sign=0 gives +mag; sign=1 gives -(mag+1) (ones-complement of magnitude, sign-extended); 9-bit examples: 0x000 -> 0, 0x100 -> -1, 0x1FF -> -256.
REQ-019 Term = converted sample times zero-extended volume, computed at SMP_W+VOL_W+1 bits without loss.
REQ-020 Each enabled cycle with i_SMP_VALID=1 and the class not muted adds the term to the class accumulator (MO or RO) and to the mix accumulator.
REQ-021 Every add saturates independently per accumulator to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets the frame saturation flag; a later add may move the value off the rail.
REQ-022 Enabled cycle with i_FRAME_START=1: outputs latch the accumulators as they stood before this cycle; o_SAT latches the frame saturation flag; accumulators reload with only this cycle's term (0 if invalid or muted); the frame flag reloads with this term's own saturation, always 0 at default widths.
REQ-023 Publish latency: o_ACC_* change on the same enabled edge that samples i_FRAME_START.
REQ-024 o_ACC_STRB rises on the publishing edge, stays high exactly STRB_LEN enabled cycles, then falls; a frame start while high restarts the count (no low gap).
REQ-025 o_FRAME_CNT increments on each publishing edge; 255 wraps to 0.
REQ-026 The first frame start after reset publishes whatever accumulated since reset (0 if nothing valid).
REQ-027 Mute and volume are sampled per slot; changes mid-frame affect only later slots.
REQ-028 Inputs are ignored while i_phi1_NCEN_n=1; every register holds.

Reset
REQ-029 i_RST=1 asynchronously clears all accumulators, o_ACC_MO/RO/MIX=0, o_ACC_STRB=0, o_SAT=0, o_FRAME_CNT=0, frame flag 0 and strobe counter 0, regardless of clock enable.
REQ-030 Reset release takes effect at the next enabled edge; reset mid-frame discards the partial sums and does not publish them.

Verification
REQ-031 Defaults; frame of MO samples 0x005,0x105 at MOVOL=2, then frame start -> o_ACC_MO=-2, o_ACC_RO=0, o_ACC_MIX=-2, strobe high 9 enabled cycles, o_FRAME_CNT=1.
REQ-032 MO 0x0FF vol 15 and RO 0x1FF vol 15 in one frame -> o_ACC_MO=3825, o_ACC_RO=-3840, o_ACC_MIX=-15, o_SAT=0.
REQ-033 ACC_W=12, nine MO adds of 255x15 -> o_ACC_MO=2047, o_SAT=1; following frame with no adds -> o_SAT=0, outputs 0.
REQ-034 Valid sample coincident with frame start -> excluded from published value, present in next frame; frame starts 4 enabled cycles apart -> strobe continuously high; toggling i_phi1_NCEN_n high stretches strobe proportionally.
REQ-035 i_MUTE_RO=1 with RO 0x050 vol 4 -> o_ACC_RO=0, o_ACC_MIX unchanged; 256 frame starts -> o_FRAME_CNT wraps to 0.
REQ-036 Assert i_RST mid-frame with partial sum 100 and strobe high -> all outputs 0 immediately (no clock edge needed); next frame start publishes 0.

Source files
------------

// File: rtl/ikaopll_dac_mixacc.sv
// Per-frame accumulator for the DAC stage: converts sign-magnitude operator
// outputs, applies class volume, and publishes saturated MO/RO/mix sums.
module ikaopll_dac_mixacc #(
    parameter int SMP_W    = 9,
    parameter int VOL_W    = 4,
    parameter int ACC_W    = 16,
    parameter int STRB_LEN = 9
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_RST,
    input  logic                    i_phi1_NCEN_n,
    input  logic                    i_FRAME_START,
    input  logic                    i_SMP_VALID,
    input  logic                    i_SMP_CLASS,
    input  logic [SMP_W-1:0]        i_SMP,
    input  logic [VOL_W-1:0]        i_MOVOL,
    input  logic [VOL_W-1:0]        i_ROVOL,
    input  logic                    i_MUTE_MO,
    input  logic                    i_MUTE_RO,
    output logic signed [ACC_W-1:0] o_ACC_MO,
    output logic signed [ACC_W-1:0] o_ACC_RO,
    output logic signed [ACC_W-1:0] o_ACC_MIX,
    output logic                    o_ACC_STRB,
    output logic                    o_SAT,
    output logic [7:0]              o_FRAME_CNT
);

    localparam int TW = SMP_W + VOL_W + 1;
    localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;

    localparam logic signed [SW-1:0] ACC_MAX = SW'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;

    // {saturated, value}: add at a width that cannot overflow, then clamp
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [TW-1:0]    t
    );
        logic signed [SW-1:0] s;
        s = SW'(a) + SW'(t);
        if (s > ACC_MAX) begin
            return {1'b1, ACC_MAX[ACC_W-1:0]};
        end else if (s < ACC_MIN) begin
            return {1'b1, ACC_MIN[ACC_W-1:0]};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    logic signed [ACC_W-1:0] mo_q, mo_d;
    logic signed [ACC_W-1:0] ro_q, ro_d;
    logic signed [ACC_W-1:0] mix_q, mix_d;
    logic                    flag_q, flag_d;
    logic signed [ACC_W-1:0] out_mo_q, out_mo_d;
    logic signed [ACC_W-1:0] out_ro_q, out_ro_d;
    logic signed [ACC_W-1:0] out_mix_q, out_mix_d;
    logic                    sat_q, sat_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [4:0]              strb_q, strb_d;

    logic                    sgn;
    logic signed [SMP_W-1:0] conv;
    logic [VOL_W-1:0]        vol;
    logic                    use_smp;
    logic signed [TW-1:0]    term;
    logic signed [TW-1:0]    t_mo, t_ro, t_mix;
    logic signed [ACC_W-1:0] b_mo, b_ro, b_mix;
    logic                    s_mo, s_ro, s_mix;

    always_comb begin
        sgn     = i_SMP[SMP_W-1];
        conv    = {sgn, i_SMP[SMP_W-2:0] ^ {(SMP_W-1){sgn}}};
        vol     = i_SMP_CLASS ? i_ROVOL : i_MOVOL;
        use_smp = i_SMP_VALID & ~(i_SMP_CLASS ? i_MUTE_RO : i_MUTE_MO);
        term    = TW'(conv) * $signed(TW'({1'b0, vol}));
        t_mo    = (use_smp & ~i_SMP_CLASS) ? term : '0;
        t_ro    = (use_smp & i_SMP_CLASS) ? term : '0;
        t_mix   = use_smp ? term : '0;
    end

    // A frame start publishes the old sums and restarts from this slot's term
    always_comb begin
        b_mo  = i_FRAME_START ? '0 : mo_q;
        b_ro  = i_FRAME_START ? '0 : ro_q;
        b_mix = i_FRAME_START ? '0 : mix_q;

        {s_mo, mo_d}   = sat_add(b_mo, t_mo);
        {s_ro, ro_d}   = sat_add(b_ro, t_ro);
        {s_mix, mix_d} = sat_add(b_mix, t_mix);

        flag_d = (i_FRAME_START ? 1'b0 : flag_q) | s_mo | s_ro | s_mix;

        out_mo_d  = out_mo_q;
        out_ro_d  = out_ro_q;
        out_mix_d = out_mix_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        strb_d    = (strb_q != 5'd0) ? strb_q - 5'd1 : 5'd0;

        if (i_FRAME_START) begin
            out_mo_d  = mo_q;
            out_ro_d  = ro_q;
            out_mix_d = mix_q;
            sat_d     = flag_q;
            cnt_d     = cnt_q + 8'd1;
            strb_d    = 5'(STRB_LEN);
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            mo_q      <= '0;
            ro_q      <= '0;
            mix_q     <= '0;
            flag_q    <= 1'b0;
            out_mo_q  <= '0;
            out_ro_q  <= '0;
            out_mix_q <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= 8'd0;
            strb_q    <= 5'd0;
        end else if (!i_phi1_NCEN_n) begin
            mo_q      <= mo_d;
            ro_q      <= ro_d;
            mix_q     <= mix_d;
            flag_q    <= flag_d;
            out_mo_q  <= out_mo_d;
            out_ro_q  <= out_ro_d;
            out_mix_q <= out_mix_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            strb_q    <= strb_d;
        end
    end

    assign o_ACC_MO    = out_mo_q;
    assign o_ACC_RO    = out_ro_q;
    assign o_ACC_MIX   = out_mix_q;
    assign o_SAT       = sat_q;
    assign o_FRAME_CNT = cnt_q;
    assign o_ACC_STRB  = (strb_q != 5'd0);

endmodule

// File: tb/tb_ikaopll_dac_mixacc.sv
// Bench for ikaopll_dac_mixacc: default-width and 12-bit-accumulator instances
// checked every cycle against an integer frame model plus literal pins.
module tb_ikaopll_dac_mixacc;

    logic clk = 1'b0;
    logic rst, ncen, fs, vld, cls;
    logic [8:0] smp;
    logic [3:0] movol, rovol;
    logic mute_mo, mute_ro;

    logic signed [15:0] mo16, ro16, mix16;
    logic strb16, sat16;
    logic [7:0] cnt16;
    logic signed [11:0] mo12, ro12, mix12;
    logic strb12, sat12;
    logic [7:0] cnt12;

    always #5 clk = ~clk;

    ikaopll_dac_mixacc dut16 (
        .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen),
        .i_FRAME_START(fs), .i_SMP_VALID(vld), .i_SMP_CLASS(cls), .i_SMP(smp),
        .i_MOVOL(movol), .i_ROVOL(rovol), .i_MUTE_MO(mute_mo), .i_MUTE_RO(mute_ro),
        .o_ACC_MO(mo16), .o_ACC_RO(ro16), .o_ACC_MIX(mix16),
        .o_ACC_STRB(strb16), .o_SAT(sat16), .o_FRAME_CNT(cnt16)
    );

    ikaopll_dac_mixacc #(.ACC_W(12)) dut12 (
        .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen),
        .i_FRAME_START(fs), .i_SMP_VALID(vld), .i_SMP_CLASS(cls), .i_SMP(smp),
        .i_MOVOL(movol), .i_ROVOL(rovol), .i_MUTE_MO(mute_mo), .i_MUTE_RO(mute_ro),
        .o_ACC_MO(mo12), .o_ACC_RO(ro12), .o_ACC_MIX(mix12),
        .o_ACC_STRB(strb12), .o_SAT(sat12), .o_FRAME_CNT(cnt12)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    // model state: index 0 = 16-bit instance, 1 = 12-bit; [0]=MO [1]=RO [2]=MIX
    int macc[2][3];
    int pacc[2][3];
    bit mflag[2];
    bit psat[2];
    int mcnt;
    int since;
    bit pubd;

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int clampv(int v, int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int conv(logic [8:0] s);
        if (s[8]) return -(int'(s[7:0]) + 1);
        return int'(s[7:0]);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                macc[k][j] = 0;
                pacc[k][j] = 0;
            end
            mflag[k] = 0;
            psat[k] = 0;
        end
        mcnt = 0;
        since = 0;
        pubd = 0;
    endtask

    task automatic model_edge(bit f, bit v, bit c, logic [8:0] s);
        int t[3];
        int tm;
        int nv;
        int w;
        bit muted;
        muted = c ? mute_ro : mute_mo;
        tm = (v && !muted) ? conv(s) * (c ? int'(rovol) : int'(movol)) : 0;
        t[0] = c ? 0 : tm;
        t[1] = c ? tm : 0;
        t[2] = tm;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 16 : 12;
            if (f) begin
                for (int j = 0; j < 3; j++) begin
                    pacc[k][j] = macc[k][j];
                    macc[k][j] = 0;
                end
                psat[k] = mflag[k];
                mflag[k] = 0;
            end
            for (int j = 0; j < 3; j++) begin
                nv = macc[k][j] + t[j];
                macc[k][j] = clampv(nv, w);
                if (macc[k][j] != nv) mflag[k] = 1;
            end
        end
        if (f) begin
            mcnt = (mcnt + 1) % 256;
            since = 0;
            pubd = 1;
        end else begin
            since++;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("mo16", mo16, pacc[0][0]);
            check("ro16", ro16, pacc[0][1]);
            check("mix16", mix16, pacc[0][2]);
            check("sat16", int'(sat16), int'(psat[0]));
            check("strb16", int'(strb16), int'(pubd && since < 9));
            check("cnt16", int'(cnt16), mcnt);
            check("mo12", mo12, pacc[1][0]);
            check("ro12", ro12, pacc[1][1]);
            check("mix12", mix12, pacc[1][2]);
            check("sat12", int'(sat12), int'(psat[1]));
            check("strb12", int'(strb12), int'(pubd && since < 9));
            check("cnt12", int'(cnt12), mcnt);
        end
    end

    task automatic step(bit f, bit v, bit c, logic [8:0] s, bit off);
        @(negedge clk);
        fs = f;
        vld = v;
        cls = c;
        smp = s;
        ncen = off;
        @(posedge clk);
        #1;
        if (!off) model_edge(f, v, c, s);
        fs = 0;
        vld = 0;
        ncen = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 9'h000, 0);
    endtask

    task automatic rst_checks(string tag);
        check({tag, "_mo16"}, mo16, 0);
        check({tag, "_mix16"}, mix16, 0);
        check({tag, "_strb16"}, int'(strb16), 0);
        check({tag, "_cnt16"}, int'(cnt16), 0);
        check({tag, "_sat16"}, int'(sat16), 0);
        check({tag, "_mo12"}, mo12, 0);
    endtask

    task automatic do_reset(string tag);
        #2;
        rst = 1;
        model_clear();
        #1;
        rst_checks(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 0; ncen = 0; fs = 0; vld = 0; cls = 0; smp = '0;
        movol = 0; rovol = 0; mute_mo = 0; mute_ro = 0;
        model_clear();
        #2;
        rst = 1;
        #1;
        rst_checks("por");
        cmp_on = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // basic melody frame
        movol = 2;
        step(0, 1, 0, 9'h005, 0);
        step(0, 1, 0, 9'h105, 0);
        step(1, 0, 0, 9'h000, 0);
        check("f1_mo", mo16, -2);
        check("f1_ro", ro16, 0);
        check("f1_mix", mix16, -2);
        check("f1_cnt", int'(cnt16), 1);
        check("f1_strb", int'(strb16), 1);
        repeat (8) idle();
        check("strb_8", int'(strb16), 1);
        idle();
        check("strb_9", int'(strb16), 0);

        // both classes at full scale
        movol = 15;
        rovol = 15;
        step(0, 1, 0, 9'h0FF, 0);
        step(0, 1, 1, 9'h1FF, 0);
        step(1, 0, 0, 9'h000, 0);
        check("fs_mo", mo16, 3825);
        check("fs_ro", ro16, -3840);
        check("fs_mix", mix16, -15);
        check("fs_sat", int'(sat16), 0);
        check("fs_mix12", mix12, -1793);
        check("fs_sat12", int'(sat12), 1);

        // saturation in the narrow accumulator
        repeat (9) step(0, 1, 0, 9'h0FF, 0);
        step(1, 0, 0, 9'h000, 0);
        check("sat_mo12", mo12, 2047);
        check("sat_sat12", int'(sat12), 1);
        check("sat_mo16", mo16, 32767);
        step(1, 0, 0, 9'h000, 0);
        check("clr_sat12", int'(sat12), 0);
        check("clr_mo12", mo12, 0);

        // sample on frame start belongs to the next frame; back-to-back strobes
        step(1, 1, 0, 9'h003, 0);
        check("fsv_mo", mo16, 0);
        repeat (3) idle();
        step(1, 0, 0, 9'h000, 0);
        check("fsv_next", mo16, 45);
        check("fsv_strb", int'(strb16), 1);

        // disabled cycles stretch the strobe and ignore inputs
        step(1, 0, 0, 9'h000, 0);
        step(1, 1, 0, 9'h0FF, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 9'h010, 1);
            idle();
        end
        check("stretch_strb", int'(strb16), 1);
        check("stretch_mo", mo16, 0);
        idle();
        check("stretch_low", int'(strb16), 0);

        // muting and mid-frame control changes
        do_reset("r1");
        mute_ro = 1;
        rovol = 4;
        movol = 1;
        step(0, 1, 1, 9'h050, 0);
        step(0, 1, 0, 9'h007, 0);
        step(1, 0, 0, 9'h000, 0);
        check("mute_ro", ro16, 0);
        check("mute_mix", mix16, 7);
        step(0, 1, 1, 9'h050, 0);
        mute_ro = 0;
        step(0, 1, 1, 9'h050, 0);
        rovol = 1;
        step(0, 1, 1, 9'h050, 0);
        mute_ro = 1;
        step(1, 0, 0, 9'h000, 0);
        check("mid_ro", ro16, 400);

        // frame counter wrap
        do_reset("r2");
        repeat (255) step(1, 0, 0, 9'h000, 0);
        check("cnt_255", int'(cnt16), 255);
        step(1, 0, 0, 9'h000, 0);
        check("cnt_wrap", int'(cnt16), 0);

        // asynchronous reset mid-frame with strobe high
        do_reset("r3");
        step(1, 0, 0, 9'h000, 0);
        movol = 2;
        step(0, 1, 0, 9'h032, 0);
        check("pre_strb", int'(strb16), 1);
        ncen = 1;
        do_reset("async");
        ncen = 0;
        step(1, 0, 0, 9'h000, 0);
        check("post_mo", mo16, 0);
        check("post_mix", mix16, 0);
        check("post_cnt", int'(cnt16), 1);

        repeat (2) idle();
        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
